// File: rtl/jimmy_out_port_capture_if.sv
// rtl/jimmy_out_port_capture_if.sv - capture FIFO head handshake interface
//
// Carries the head entry of the capture FIFO to its consumer.
//   cap_data  : head entry data (DW bits)
//   cap_chan  : head entry channel index
//   cap_valid : head entry present
//   cap_ready : consumer accepts the head entry
// master = capture block (drives head), slave = consumer (drives ready).
interface jimmy_out_port_capture_if #(
    parameter int DW = 8
);
    logic [DW-1:0] cap_data;
    logic [1:0]    cap_chan;
    logic          cap_valid;
    logic          cap_ready;

    modport master (
        output cap_data,
        output cap_chan,
        output cap_valid,
        input  cap_ready
    );

    modport slave (
        input  cap_data,
        input  cap_chan,
        input  cap_valid,
        output cap_ready
    );
endinterface

// File: rtl/jimmy_out_port_capture.sv
// rtl/jimmy_out_port_capture.sv - CPU output-port strobe capture into a FIFO
//
// Captures a CPU output-port write on the falling edge of its strobe and
// queues {channel, data} for a downstream consumer.
//   jimmy_clk   : clock, rising edge
//   reset       : asynchronous active-low reset
//   out_port_0  : CPU output-port data bus
//   out_strobe  : one strobe per port channel
//   cap         : FIFO head handshake (master modport)
//   count       : number of stored entries (0..DEPTH)
//   overflow    : sticky, a capture was dropped while full
//   collision   : sticky, several strobes fell in the same cycle
//   clear_flags : synchronous clear of overflow and collision
module jimmy_out_port_capture #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                       jimmy_clk,
    input  logic                       reset,
    input  logic [DW-1:0]              out_port_0,
    input  logic [3:0]                 out_strobe,
    jimmy_out_port_capture_if.master   cap,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       collision,
    input  logic                       clear_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [3:0]    strb_q;
    logic [3:0]    fall;
    logic [DW-1:0] hold;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem_data [DEPTH];
    logic [1:0]    mem_chan [DEPTH];

    logic          push;
    logic [1:0]    push_chan;
    logic          multi_fall;
    logic          valid;
    logic          full;
    logic          pop;
    logic          do_write;
    logic          ovf_set;

    assign fall       = strb_q & ~out_strobe;
    assign push       = |fall;
    // Clearing the lowest set bit leaves something only if two or more fell.
    assign multi_fall = (fall & (fall - 4'd1)) != 4'd0;

    always_comb begin
        push_chan = 2'd0;
        if (fall[0])      push_chan = 2'd0;
        else if (fall[1]) push_chan = 2'd1;
        else if (fall[2]) push_chan = 2'd2;
        else if (fall[3]) push_chan = 2'd3;
    end

    assign valid    = count != '0;
    assign full     = count == FULL_CNT;
    assign pop      = valid & cap.cap_ready;
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign do_write = push & (~full | pop);
    assign ovf_set  = push & full & ~pop;

    assign cap.cap_valid = valid;
    assign cap.cap_data  = valid ? mem_data[rd_ptr] : '0;
    assign cap.cap_chan  = valid ? mem_chan[rd_ptr] : 2'd0;

    always_ff @(posedge jimmy_clk or negedge reset) begin
        if (!reset) begin
            strb_q    <= 4'd0;
            hold      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            strb_q <= out_strobe;
            if (|out_strobe) begin
                hold <= out_port_0;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A flag being set this cycle wins over a simultaneous clear.
            overflow  <= ovf_set | (overflow & ~clear_flags);
            collision <= (push & multi_fall) | (collision & ~clear_flags);
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge jimmy_clk) begin
        if (do_write) begin
            mem_data[wr_ptr] <= hold;
            mem_chan[wr_ptr] <= push_chan;
        end
    end
endmodule
